// File: rtl/dp_result_collector.sv
// Serializes the two dot-product adder result streams into one output stream
// (lane interleave in split mode, lane-1 sums only in add mode) and signals job completion.
module dp_result_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    test_mode_i,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic                    add_enable_i,
    input  logic [CNT_WIDTH-1:0]    n_results_i,
    input  logic                    in0_valid_i,
    output logic                    in0_ready_o,
    input  logic [DATA_WIDTH-1:0]   in0_data_i,
    input  logic [DATA_WIDTH/8-1:0] in0_strb_i,
    input  logic                    in1_valid_i,
    output logic                    in1_ready_o,
    input  logic [DATA_WIDTH-1:0]   in1_data_i,
    input  logic [DATA_WIDTH/8-1:0] in1_strb_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [DATA_WIDTH-1:0]   out_data_o,
    output logic [DATA_WIDTH/8-1:0] out_strb_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, TAKE0, TAKE1, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [CNT_WIDTH-1:0]    cnt_reg, cnt_next;
    logic [CNT_WIDTH-1:0]    len_reg, len_next;
    logic                    add_reg, add_next;
    logic                    out_valid_reg, out_valid_next;
    logic [DATA_WIDTH-1:0]   out_data_reg, out_data_next;
    logic [STRB_WIDTH-1:0]   out_strb_reg, out_strb_next;
    logic                    busy_reg, busy_next;
    logic                    done_reg, done_next;

    logic                    can_load;
    logic                    hs0, hs1;
    logic [CNT_WIDTH-1:0]    cnt_inc;
    logic                    unused_test_mode;

    assign unused_test_mode = test_mode_i;

    // The output register can take a new beat when empty or draining this cycle.
    assign can_load    = !out_valid_reg || out_ready_i;
    assign in0_ready_o = (state_reg == TAKE0) && can_load;
    assign in1_ready_o = (state_reg == TAKE1) && can_load;
    assign hs0         = in0_valid_i && in0_ready_o;
    assign hs1         = in1_valid_i && in1_ready_o;
    assign cnt_inc     = cnt_reg + CNT_ONE;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        len_next       = len_reg;
        add_next       = add_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        out_data_next  = out_data_reg;
        out_strb_next  = out_strb_reg;
        out_valid_next = out_ready_i ? 1'b0 : out_valid_reg;

        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    len_next  = n_results_i;
                    add_next  = add_enable_i;
                    cnt_next  = '0;
                    busy_next = 1'b1;
                    if (n_results_i == '0)
                        state_next = DONE;
                    else
                        state_next = add_enable_i ? TAKE1 : TAKE0;
                end
            end
            TAKE0: begin
                if (hs0) begin
                    cnt_next   = cnt_inc;
                    state_next = (cnt_inc == len_reg) ? DONE : TAKE1;
                end
            end
            TAKE1: begin
                if (hs1) begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == len_reg)
                        state_next = DONE;
                    else
                        state_next = add_reg ? TAKE1 : TAKE0;
                end
            end
            DONE: begin
                // Finish once the last beat has left the output register.
                if (can_load) begin
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (hs0) begin
            out_data_next  = in0_data_i;
            out_strb_next  = in0_strb_i;
            out_valid_next = 1'b1;
        end else if (hs1) begin
            out_data_next  = in1_data_i;
            out_strb_next  = in1_strb_i;
            out_valid_next = 1'b1;
        end

        if (clear_i) begin
            state_next     = IDLE;
            cnt_next       = '0;
            out_valid_next = 1'b0;
            busy_next      = 1'b0;
            done_next      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            len_reg       <= '0;
            add_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_strb_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            len_reg       <= len_next;
            add_reg       <= add_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_strb_reg  <= out_strb_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    assign out_valid_o = out_valid_reg;
    assign out_data_o  = out_data_reg;
    assign out_strb_o  = out_strb_reg;
    assign busy_o      = busy_reg;
    assign done_o      = done_reg;

endmodule

// File: doc/dp_result_collector.md
# dp_result_collector

Collects the two result streams produced by the dot-product result adder and serializes them into the single result stream that feeds the output streamer. In split mode it interleaves lane-0 and lane-1 results (0,1,0,1,...); in add mode it forwards only the lane-1 sum stream. It counts delivered results against a job length and signals job completion. Sits between the result adder and the HWPE output streamer, controlled by the engine FSM.

## Interface

Parameters:
- DATA_WIDTH, 32, width of every stream data bus; strb width is DATA_WIDTH/8.
- CNT_WIDTH, 16, width of the result counter and of n_results_i.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- test_mode_i  in  1  unused; no functional effect.
- clear_i  in  1  synchronous abort; returns the block to IDLE.
- start_i  in  1  one-cycle job start pulse; honoured only in IDLE.
- add_enable_i  in  1  mode select, sampled at start: 1 = add mode, 0 = split mode.
- n_results_i  in  CNT_WIDTH  number of output beats in the job, sampled at start.
- in0_i  sink  hwpe_stream  lane-0 results (adder0 output).
- in1_i  sink  hwpe_stream  lane-1 results or sums (adder1 output).
- out_o  source  hwpe_stream  serialized result stream.
- busy_o  out  1  high from the cycle after an accepted start until done.
- done_o  out  1  one-cycle completion pulse.

## Operation

- States: IDLE, TAKE0, TAKE1, DONE.
- IDLE: start_i=1 latches mode and length, clears the counter, and moves to DONE if n_results_i==0. Otherwise it moves to TAKE1 in add mode or TAKE0 in split mode.
- TAKE0: in0_i.ready = (!out_o.valid || out_o.ready). On an in0 handshake, load the output register and go to TAKE1.
- TAKE1: in1_i.ready uses the same rule as TAKE0. On an in1 handshake, load the output register. Then go to TAKE0 in split mode or stay in TAKE1 in add mode.
- The ready of the input not selected by the state is 0. All input readies are 0 in IDLE and DONE.
- Output register: data and strb are copied unmodified from the accepted beat. Valid is set on load and cleared on an out_o handshake unless it is reloaded in the same cycle.
- Counter increments on each input handshake. When the counter reaches the latched length, inputs stop being accepted and the FSM goes to DONE.
- DONE: wait until out_o.valid==0, or until the out_o handshake of the last beat completes. Then pulse done_o for one cycle and return to IDLE.
- A start_i that arrives outside IDLE is ignored.
- clear_i has priority over everything else. On the next edge: state=IDLE, counter=0, out_o.valid=0, and done_o is not pulsed.
- Length counts output beats. A split-mode job with an odd length ends after an in0 beat.

## Timing

- Reset values: out_o.valid=0, out_o.data=0, out_o.strb=0, in0_i.ready=0, in1_i.ready=0, busy_o=0, done_o=0, state=IDLE, counter=0.
- in*_i.ready is combinational from state, out_o.valid and out_o.ready. There is no combinational data path from input to output.
- Latency: input handshake at edge N puts out_o.valid=1 at N+1. Throughput is 1 beat per cycle while out_o.ready=1.
- Backpressure: while out_o.valid=1 and out_o.ready=0, out_o data, strb and valid are held stable and input readies are 0.
- done_o asserts the cycle after the last output handshake. busy_o drops in the same cycle that done_o asserts.
- For start with n=0: done_o asserts 2 cycles after start, with no stream activity.

## Test plan

- Split mode, n=4, in0 beats A0,A1 and in1 beats B0,B1 always valid, out ready=1: out sequence is A0,B0,A1,B1 on 4 consecutive cycles starting 1 cycle after the first accept; then a single done_o pulse.
- Add mode, n=3, in1 beats S0..S2, in0 held valid with 0xDEAD: out is S0,S1,S2; in0_i.ready stays 0 throughout.
- Backpressure: split mode n=4, out_o.ready=0 for 3 cycles after the first beat: out data is held stable, no input is accepted, final order is unchanged and no beat is lost.
- n_results_i=0: no ready asserted, out_o.valid stays 0, done_o pulses exactly once.
- clear_i asserted after 2 of 6 beats, with out_o.valid=1: out_o.valid=0 next cycle, no done_o, busy_o=0. A new start then runs a full job correctly.
- start_i pulsed while busy with different mode and length: ignored; the current job completes with its original parameters.
